// File: rtl/jk_excite_driver.sv
// JK flip-flop excitation driver: turns a stream of target bits into registered J/K drive,
// then verifies the flip-flop's feedback and keeps a saturating mismatch count.
module jk_excite_driver #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DC_FILL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_fb,
  input  logic             err_clr,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic FILL = (DC_FILL != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             tgt_q, tgt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch;

  assign tgt_ready = (state_q == IDLE);
  assign busy      = (state_q == DRIVE) || (state_q == CHECK);
  assign j         = j_q;
  assign k         = k_q;
  assign err       = err_q;
  assign err_cnt   = cnt_q;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    j_d      = j_q;
    k_d      = k_q;
    err_d    = 1'b0;
    mismatch = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          state_d = DRIVE;
          tgt_d   = tgt_bit;
          // Excitation table keyed on current q: the don't-care side takes FILL.
          j_d     = q_fb ? FILL : tgt_bit;
          k_d     = q_fb ? ~tgt_bit : FILL;
        end
      end
      DRIVE: begin
        state_d = CHECK;
        j_d     = 1'b0;
        k_d     = 1'b0;
      end
      CHECK: begin
        state_d  = IDLE;
        mismatch = (q_fb != tgt_q);
        err_d    = mismatch;
      end
      default: begin
        state_d = IDLE;
        j_d     = 1'b0;
        k_d     = 1'b0;
      end
    endcase

    if (err_clr) begin
      cnt_d = '0;
    end else if (mismatch && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench: two drivers (hold/toggle fill) on behavioural JK flops, two on stuck-at-0 flops.
module tb_jk_excite_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic tgt_valid;
  logic tgt_bit_ab, tgt_bit_cd;
  logic err_clr, err_clr_c;

  logic ready_a, j_a, k_a, busy_a, err_a;
  logic ready_b, j_b, k_b, busy_b, err_b;
  logic ready_c, j_c, k_c, busy_c, err_c;
  logic ready_d, j_d, k_d, busy_d, err_d;
  logic [7:0] cnt_a, cnt_b, cnt_d;
  logic [1:0] cnt_c;
  logic q_a, q_b;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  jk_excite_driver #(.CNT_W(8), .DC_FILL(0)) u_a (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit_ab),
    .tgt_ready(ready_a), .q_fb(q_a), .err_clr(err_clr), .j(j_a), .k(k_a),
    .busy(busy_a), .err(err_a), .err_cnt(cnt_a));

  jk_excite_driver #(.CNT_W(8), .DC_FILL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit_ab),
    .tgt_ready(ready_b), .q_fb(q_b), .err_clr(err_clr), .j(j_b), .k(k_b),
    .busy(busy_b), .err(err_b), .err_cnt(cnt_b));

  jk_excite_driver #(.CNT_W(2), .DC_FILL(0)) u_c (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit_cd),
    .tgt_ready(ready_c), .q_fb(1'b0), .err_clr(err_clr_c), .j(j_c), .k(k_c),
    .busy(busy_c), .err(err_c), .err_cnt(cnt_c));

  jk_excite_driver #(.CNT_W(8), .DC_FILL(0)) u_d (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit_cd),
    .tgt_ready(ready_d), .q_fb(1'b0), .err_clr(err_clr), .j(j_d), .k(k_d),
    .busy(busy_d), .err(err_d), .err_cnt(cnt_d));

  // Behavioural JK flip-flops driven by u_a and u_b.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a <= 1'b0;
      q_b <= 1'b0;
    end else begin
      case ({j_a, k_a})
        2'b01: q_a <= 1'b0;
        2'b10: q_a <= 1'b1;
        2'b11: q_a <= ~q_a;
        default: q_a <= q_a;
      endcase
      case ({j_b, k_b})
        2'b01: q_b <= 1'b0;
        2'b10: q_b <= 1'b1;
        2'b11: q_b <= ~q_b;
        default: q_b <= q_b;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One full bit: transfer edge, DRIVE-ending edge, CHECK-ending edge.
  task automatic send(input logic b, input logic [15:0] jk_a_exp, input logic [15:0] jk_b_exp,
                      input logic [15:0] cnt_c_exp, input logic [15:0] cnt_d_exp, input bit clr_c);
    tgt_bit_ab = b;
    tgt_bit_cd = 1'b1;
    tgt_valid  = 1'b1;
    @(posedge clk); #1;
    chk("jk_a_drive", 16'({j_a, k_a}), jk_a_exp);
    chk("jk_b_drive", 16'({j_b, k_b}), jk_b_exp);
    chk("jk_c_drive", 16'({j_c, k_c}), 16'h2);
    chk("ready_drive", 16'(ready_a), 16'h0);
    chk("busy_drive", 16'(busy_a), 16'h1);
    chk("err_c_one_cycle", 16'(err_c), 16'h0);
    tgt_bit_ab = ~b;
    tgt_bit_cd = 1'b0;
    @(posedge clk); #1;
    chk("jk_a_check", 16'({j_a, k_a}), 16'h0);
    chk("jk_b_check", 16'({j_b, k_b}), 16'h0);
    chk("q_a", 16'(q_a), 16'(b));
    chk("q_b", 16'(q_b), 16'(b));
    chk("ready_check", 16'(ready_b), 16'h0);
    chk("busy_check", 16'(busy_b), 16'h1);
    err_clr_c = clr_c;
    @(posedge clk); #1;
    err_clr_c = 1'b0;
    chk("err_a", 16'(err_a), 16'h0);
    chk("err_b", 16'(err_b), 16'h0);
    chk("err_c", 16'(err_c), 16'h1);
    chk("err_d", 16'(err_d), 16'h1);
    chk("cnt_a", 16'(cnt_a), 16'h0);
    chk("cnt_b", 16'(cnt_b), 16'h0);
    chk("cnt_c", 16'(cnt_c), cnt_c_exp);
    chk("cnt_d", 16'(cnt_d), cnt_d_exp);
    chk("ready_idle", 16'(ready_a), 16'h1);
    chk("busy_idle", 16'(busy_c), 16'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    tgt_valid  = 1'b0;
    tgt_bit_ab = 1'b0;
    tgt_bit_cd = 1'b0;
    err_clr    = 1'b0;
    err_clr_c  = 1'b0;
    #2;
    chk("rst_ready", 16'(ready_a), 16'h1);
    chk("rst_busy", 16'(busy_a), 16'h0);
    chk("rst_jk", 16'({j_a, k_a, j_b, k_b}), 16'h0);
    chk("rst_err", 16'({err_a, err_c}), 16'h0);
    chk("rst_cnt_d", 16'(cnt_d), 16'h0);
    #6 rst_n = 1'b1;

    @(posedge clk); #1;
    chk("idle_hold_ready", 16'(ready_a), 16'h1);
    chk("idle_hold_busy", 16'(busy_a), 16'h0);

    // Sequence 1,0,0,1,1 from q=0 with tgt_valid held high throughout.
    send(1'b1, 16'h2, 16'h3, 16'h1, 16'h1, 1'b0);
    send(1'b0, 16'h1, 16'h3, 16'h2, 16'h2, 1'b0);
    send(1'b0, 16'h0, 16'h1, 16'h3, 16'h3, 1'b0);
    send(1'b1, 16'h2, 16'h3, 16'h3, 16'h4, 1'b0);
    send(1'b1, 16'h0, 16'h2, 16'h0, 16'h5, 1'b1);

    // Abort a bit with reset mid-DRIVE.
    tgt_bit_ab = 1'b0;
    tgt_bit_cd = 1'b1;
    @(posedge clk); #1;
    chk("abort_j_c", 16'({j_c, k_c}), 16'h2);
    chk("abort_jk_a", 16'({j_a, k_a}), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_jk_c", 16'({j_c, k_c}), 16'h0);
    chk("abort_jk_a0", 16'({j_a, k_a}), 16'h0);
    chk("abort_ready", 16'(ready_c), 16'h1);
    chk("abort_busy", 16'(busy_c), 16'h0);
    chk("abort_err", 16'(err_c), 16'h0);
    chk("abort_cnt_d", 16'(cnt_d), 16'h0);
    #1 rst_n = 1'b1;

    // First edge after reset release transfers immediately.
    @(posedge clk); #1;
    chk("post_rst_busy", 16'(busy_a), 16'h1);
    chk("post_rst_jk_b", 16'({j_b, k_b}), 16'h1);
    tgt_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_err_c", 16'(err_c), 16'h1);
    chk("post_rst_cnt_c", 16'(cnt_c), 16'h1);
    @(posedge clk); #1;
    chk("valid_low_idle", 16'(busy_a), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
